oem_bank_write_scheduler: RTL

//  Sequences the pixel byte stream from the serializer/DAC path into the eight pixel memories (ODD1..4, EVEN1..4).
//  - 256 pixels form a 4-quadrant image: pixel idx 0..255; quadrant q = idx[7:6] selects bank pair q+1.
//  - Inside each 8x8 quadrant the pixels are split checkerboard-wise into odd and even banks of 32 entries each.
//  - Drives the oem_* write bus with setup/strobe timing; raises oem_finish once all 256 locations are written.

---
 rtl/oem_bank_write_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/oem_bank_write_scheduler.sv
// Steers a 256-pixel byte stream into eight checkerboard-split bank memories (ODD1..4, EVEN1..4).
// Latency: 3 cycles per pixel (IDLE accept, SETUP, STROBE); oem_finish rises the cycle after the final strobe.
// Backpressure: in_ready is high only in IDLE; the source holds its byte otherwise. Option macro: OEM_ZERO_FILL_EN.
module oem_bank_write_scheduler #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int NPIX   = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] oem_addr,
  output logic [DATA_W-1:0] oem_dataout,
  output logic              odd1_wr,
  output logic              odd2_wr,
  output logic              odd3_wr,
  output logic              odd4_wr,
  output logic              even1_wr,
  output logic              even2_wr,
  output logic              even3_wr,
  output logic              even4_wr,
  output logic              oem_finish,
  output logic              busy
);

  localparam int CNT_W = $clog2(NPIX) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, FILL, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  logic             last_q;
  logic             accept;
  logic [7:0]       sel_q;
  logic [7:0]       wr_q;
  logic [2:0]       bank_idx;
  logic [7:0]       bank_onehot;

  // Bank index: low two bits pick the quadrant pair, top bit picks odd (0) or even (1)
  // from the checkerboard parity of row/column inside the 8x8 quadrant.
  assign bank_idx    = {count[3] ^ count[0], count[7:6]};
  assign bank_onehot = 8'b1 << bank_idx;

  assign busy = (state != IDLE) && (state != DONE);

  assign odd1_wr  = wr_q[0];
  assign odd2_wr  = wr_q[1];
  assign odd3_wr  = wr_q[2];
  assign odd4_wr  = wr_q[3];
  assign even1_wr = wr_q[4];
  assign even2_wr = wr_q[5];
  assign even3_wr = wr_q[6];
  assign even4_wr = wr_q[7];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: one pixel walks IDLE/FILL -> SETUP -> STROBE, then picks the next source.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP:  next_state = STROBE;
      STROBE: begin
        if (count == CNT_W'(NPIX - 1)) begin
          next_state = DONE;
        end else if (last_q) begin
`ifdef OEM_ZERO_FILL_EN
          next_state = FILL;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = IDLE;
        end
      end
      FILL:    next_state = SETUP;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs: addr/data/bank are loaded only when a pixel starts,
  // so they stay frozen through SETUP and STROBE; strobes are registered so reset drops them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready    <= 1'b0;
      oem_addr    <= '0;
      oem_dataout <= '0;
      oem_finish  <= 1'b0;
      count       <= '0;
      last_q      <= 1'b0;
      sel_q       <= '0;
      wr_q        <= '0;
    end else begin
      in_ready   <= (next_state == IDLE);
      oem_finish <= (next_state == DONE);
      wr_q       <= (next_state == STROBE) ? sel_q : 8'b0;
      if (accept) begin
        oem_dataout <= in_data;
        last_q      <= in_last;
        oem_addr    <= count[ADDR_W:1];
        sel_q       <= bank_onehot;
      end else if (state == FILL) begin
        oem_dataout <= '0;
        oem_addr    <= count[ADDR_W:1];
        sel_q       <= bank_onehot;
      end
      if (state == STROBE) count <= count + 1'b1;
    end
  end

endmodule
